// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ready handshake,
// hands the word to the decoder as IR and redirects the PC when the decoder accepts it.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IR,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic [1:0]  PCctrl,
    input  logic [31:0] Immediate,
    input  logic        branch_taken,
    input  logic [31:0] reg_target,
    input  logic        Link,
    output logic [31:0] link_addr,
    output logic [31:0] pc,
    output logic        misalign,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic        ir_valid_q;
    logic        misalign_q;
    logic [31:0] retired_q;
    logic [31:0] pc4;
    logic [31:0] pc_d;

    // Link only qualifies the write of link_addr downstream; it never steers the PC.
    logic unused_link;
    assign unused_link = Link;

    assign pc4 = pc_q + 32'd4;

    always_comb begin
        pc_d = pc4;
        case (PCctrl)
            2'd0:    pc_d = pc4;
            2'd1:    pc_d = branch_taken ? (pc4 + (Immediate << 2)) : pc4;
            2'd2:    pc_d = {reg_target[31:2], 2'b00};
            default: pc_d = {pc4[31:28], ir_q[25:0], 2'b00};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= 32'd0;
            ir_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            retired_q  <= 32'd0;
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                IDLE: state_q <= FETCH;
                FETCH: begin
                    if (imem_ready) begin
                        ir_q       <= imem_rdata;
                        ir_valid_q <= 1'b1;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    // Redirect on the accepting edge so the next request is already on-path.
                    if (ir_ready) begin
                        pc_q       <= pc_d;
                        ir_valid_q <= 1'b0;
                        retired_q  <= retired_q + 32'd1;
                        misalign_q <= (PCctrl == 2'd2) && (reg_target[1:0] != 2'b00);
                        state_q    <= FETCH;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem_req  = (state_q == FETCH);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign IR        = ir_q;
    assign ir_valid  = ir_valid_q;
    assign link_addr = pc4;
    assign misalign  = misalign_q;
    assign retired   = retired_q;

endmodule
